// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the 5-stage MIPS datapath.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    // 5-bit architectural register index (rs / rt / rd fields)
    typedef logic [4:0] regbits_t;

    // Hazard control unit states; HALT is only left through reset
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } hcu_state_t;

    // Register 0 is hard-wired to zero, so it can never carry a dependency
    localparam regbits_t c_REG_ZERO = 5'd0;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up-counter that sticks at all-ones; async reset.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count requested events, holding once the maximum value is reached
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Pipeline enable/flush control for load-use, redirect,
//               I-miss, D-miss and halt, plus stall/flush event counters.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  regbits_t         ex_regdest,
    input  logic             ex_redirect,
    input  logic             ihit,
    input  logic             dmemreq,
    input  logic             dhit,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hcu_state_t r_state;
    hcu_state_t w_next_state;

    logic w_dstall;
    logic w_loaduse;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_memwb_flush;
    logic w_halted;
    logic w_stall_evt;
    logic w_flush_evt;

    // Hazard detection terms
    assign w_dstall  = dmemreq & ~dhit;
    assign w_loaduse = ex_memread & (ex_regdest != c_REG_ZERO) &
                       ((ex_regdest == id_rs) | (id_uses_rt & (ex_regdest == id_rt)));

    // State register; reset discards any stall or halt in progress
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control outputs, highest-priority hazard first
    always_comb begin
        w_next_state  = r_state;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        w_halted      = 1'b0;
        w_stall_evt   = 1'b0;
        w_flush_evt   = 1'b0;

        if (RST) begin
            // Everything held quiet while reset is asserted
            w_next_state = RUN;
        end else if (r_state == HALT) begin
            w_halted = 1'b1;
        end else begin
            w_pc_en    = 1'b1;
            w_ifid_en  = 1'b1;
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_memwb_en = 1'b1;

            if (w_dstall) begin
                // D-miss freezes the whole pipe; a pending halt waits for dhit
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
                w_idex_en     = 1'b0;
                w_exmem_en    = 1'b0;
                w_memwb_en    = 1'b0;
                w_memwb_flush = 1'b1;
            end else if (mem_halt) begin
                // Let the halt retire into WB, freeze everything upstream
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_en    = 1'b0;
                w_exmem_en   = 1'b0;
                w_next_state = HALT;
            end else if (ex_redirect) begin
                // ID and IF hold wrong-path work; take the target even on an I-miss
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_flush_evt  = 1'b1;
            end else if (w_loaduse) begin
                // Hold the consumer in ID one cycle; ifid_flush stays low on an I-miss
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
            end else if (!ihit) begin
                // No instruction fetched: refetch and send a bubble into ID
                w_pc_en      = 1'b0;
                w_ifid_flush = 1'b1;
            end

            w_stall_evt = ~w_pc_en;
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en;
    assign idex_en     = w_idex_en;
    assign exmem_en    = w_exmem_en;
    assign memwb_en    = w_memwb_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign memwb_flush = w_memwb_flush;
    assign halted      = w_halted;

    sat_counter #(
        .W     (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_evt),
        .count (stall_cnt)
    );

    sat_counter #(
        .W     (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_flush_evt),
        .count (flush_cnt)
    );

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed, table-driven bench for hazard_control_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int c_CNT_W = 4;

    logic               CLK;
    logic               RST;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rt;
    logic               ex_memread;
    logic [4:0]         ex_regdest;
    logic               ex_redirect;
    logic               ihit;
    logic               dmemreq;
    logic               dhit;
    logic               mem_halt;
    logic               pc_en;
    logic               ifid_en;
    logic               idex_en;
    logic               exmem_en;
    logic               memwb_en;
    logic               ifid_flush;
    logic               idex_flush;
    logic               memwb_flush;
    logic               halted;
    logic [c_CNT_W-1:0] stall_cnt;
    logic [c_CNT_W-1:0] flush_cnt;

    // Control bundle: {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes}
    logic [7:0] w_ctl;
    assign w_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, memwb_flush};

    localparam logic [7:0] c_NORMAL = 8'b11111_000;
    localparam logic [7:0] c_LDUSE  = 8'b00111_010;
    localparam logic [7:0] c_IMISS  = 8'b01111_100;
    localparam logic [7:0] c_REDIR  = 8'b11111_110;
    localparam logic [7:0] c_DSTALL = 8'b00000_001;
    localparam logic [7:0] c_HALTGO = 8'b00001_000;
    localparam logic [7:0] c_QUIET  = 8'b00000_000;

    hazard_control_unit #(
        .CNT_W       (c_CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_regdest  (ex_regdest),
        .ex_redirect (ex_redirect),
        .ihit        (ihit),
        .dmemreq     (dmemreq),
        .dhit        (dhit),
        .mem_halt    (mem_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_flush (memwb_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] rd;
        logic       redirect;
        logic       ih;
        logic       dreq;
        logic       dh;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic set_idle();
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        ex_memread  = 1'b0;
        ex_regdest  = 5'd0;
        ex_redirect = 1'b0;
        ihit        = 1'b1;
        dmemreq     = 1'b0;
        dhit        = 1'b0;
        mem_halt    = 1'b0;
    endtask

    // Assert reset between edges, check the quiet reset state, release on a negedge
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        set_idle();
        #1;
        check("rst_ctl", {24'd0, w_ctl}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    int exp_stall;
    int exp_flush;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        set_idle();

        //                rs  rt  urt mr  rd  red ih dq dh  expected
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, c_NORMAL};
        vecs[1]  = '{5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, c_LDUSE};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, c_NORMAL};
        vecs[3]  = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, c_LDUSE};
        vecs[4]  = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, c_NORMAL};
        vecs[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_IMISS};
        vecs[6]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, c_LDUSE};
        vecs[7]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, c_REDIR};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, c_REDIR};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, c_DSTALL};
        vecs[10] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, c_DSTALL};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, c_NORMAL};
        vecs[12] = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, c_NORMAL};

        // ---------------- table of single-cycle vectors ----------------
        do_reset();
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 13; i++) begin
            id_rs       = vecs[i].rs;
            id_rt       = vecs[i].rt;
            id_uses_rt  = vecs[i].uses_rt;
            ex_memread  = vecs[i].memread;
            ex_regdest  = vecs[i].rd;
            ex_redirect = vecs[i].redirect;
            ihit        = vecs[i].ih;
            dmemreq     = vecs[i].dreq;
            dhit        = vecs[i].dh;
            #1;
            check($sformatf("vec%0d_ctl", i), {24'd0, w_ctl}, {24'd0, vecs[i].exp});
            check($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
            if (!vecs[i].exp[7]) exp_stall++;
            if (vecs[i].exp == c_REDIR) exp_flush++;
            @(negedge CLK);
        end
        check("table_stall_cnt", {28'd0, stall_cnt}, exp_stall);
        check("table_flush_cnt", {28'd0, flush_cnt}, exp_flush);

        // ---------------- load-use lasts one cycle ----------------
        do_reset();
        ex_memread = 1'b1; ex_regdest = 5'd8; id_rs = 5'd8;
        #1;
        check("lu_ctl", {24'd0, w_ctl}, {24'd0, c_LDUSE});
        check("lu_stall_before", {28'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        set_idle();
        #1;
        check("lu_after_ctl", {24'd0, w_ctl}, {24'd0, c_NORMAL});
        check("lu_stall_after", {28'd0, stall_cnt}, 32'd1);
        ex_memread = 1'b1; ex_regdest = 5'd0; id_rs = 5'd0;
        #1;
        check("lu_r0_ctl", {24'd0, w_ctl}, {24'd0, c_NORMAL});
        @(negedge CLK);
        check("lu_r0_stall", {28'd0, stall_cnt}, 32'd1);

        // ---------------- redirect overriding load-use ----------------
        do_reset();
        ex_memread = 1'b1; ex_regdest = 5'd8; id_rs = 5'd8; ex_redirect = 1'b1;
        #1;
        check("rd_lu_ctl", {24'd0, w_ctl}, {24'd0, c_REDIR});
        @(negedge CLK);
        set_idle();
        #1;
        check("rd_lu_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        check("rd_lu_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // ---------------- three-cycle D-miss ----------------
        do_reset();
        dmemreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dmiss%0d_ctl", i), {24'd0, w_ctl}, {24'd0, c_DSTALL});
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1;
        check("dmiss_hit_ctl", {24'd0, w_ctl}, {24'd0, c_NORMAL});
        @(negedge CLK);
        check("dmiss_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // ---------------- halt waiting on a D-miss ----------------
        do_reset();
        mem_halt = 1'b1; dmemreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("hd%0d_ctl", i), {24'd0, w_ctl}, {24'd0, c_DSTALL});
            check($sformatf("hd%0d_halted", i), {31'd0, halted}, 32'd0);
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1;
        check("hd_hit_ctl", {24'd0, w_ctl}, {24'd0, c_HALTGO});
        check("hd_hit_halted", {31'd0, halted}, 32'd0);
        @(negedge CLK);
        set_idle();
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("halt%0d_halted", i), {31'd0, halted}, 32'd1);
            check($sformatf("halt%0d_ctl", i), {24'd0, w_ctl}, {24'd0, c_QUIET});
            @(negedge CLK);
        end
        check("halt_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        check("halt_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // ---------------- asynchronous reset while halted ----------------
        #2;
        RST = 1'b1;
        #1;
        check("rh_halted", {31'd0, halted}, 32'd0);
        check("rh_ctl", {24'd0, w_ctl}, {24'd0, c_QUIET});
        check("rh_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        set_idle();
        #1;
        check("rh_release_ctl", {24'd0, w_ctl}, {24'd0, c_NORMAL});
        @(negedge CLK);
        check("rh_run_ctl", {24'd0, w_ctl}, {24'd0, c_NORMAL});
        check("rh_run_halted", {31'd0, halted}, 32'd0);

        // ---------------- stall counter saturation ----------------
        do_reset();
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 10) check("sat_10", {28'd0, stall_cnt}, 32'd10);
            if (i == 15) check("sat_15", {28'd0, stall_cnt}, 32'd15);
        end
        check("sat_20", {28'd0, stall_cnt}, 32'd15);
        check("sat_imiss_ctl", {24'd0, w_ctl}, {24'd0, c_IMISS});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_control_unit
`default_nettype wire
